// File: rtl/regfile_dump_reader_pkg.sv
// Shared widths and FSM encoding for the register-file dump reader.
package regfile_dump_reader_pkg;

    localparam int REG_ADDR_LEN = 5;
    localparam int DATA_LEN     = 32;
    localparam int REG_NUM      = 32;

    typedef enum logic [2:0] {
        DUMP_IDLE  = 3'd0,
        DUMP_DRAIN = 3'd1,
        DUMP_READ  = 3'd2,
        DUMP_SEND  = 3'd3,
        DUMP_DONE  = 3'd4
    } dump_state_t;

    function automatic logic [REG_ADDR_LEN-1:0] to_reg_addr(input int a);
        return REG_ADDR_LEN'(a);
    endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks FIRST_ADDR..LAST_ADDR through the register-file read port and streams
// {addr, data} beats, holding the CPU stalled for the whole dump.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = REG_NUM - 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic                    cpu_stall,
    output logic [REG_ADDR_LEN-1:0] rf_raddr,
    input  logic [DATA_LEN-1:0]     rf_rdata,
    output logic                    dump_valid,
    input  logic                    dump_ready,
    output logic [REG_ADDR_LEN-1:0] dump_addr,
    output logic [DATA_LEN-1:0]     dump_data,
    output logic                    busy,
    output logic                    done
);

    localparam logic [REG_ADDR_LEN-1:0] FIRST_IDX = to_reg_addr(FIRST_ADDR);
    localparam logic [REG_ADDR_LEN-1:0] LAST_IDX  = to_reg_addr(LAST_ADDR);

    dump_state_t             state;
    logic [REG_ADDR_LEN-1:0] idx;
    logic                    handshake;

    assign handshake = dump_valid & dump_ready;

    // rf_raddr is loaded one edge early so it already equals idx throughout READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DUMP_IDLE;
            idx        <= FIRST_IDX;
            cpu_stall  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dump_valid <= 1'b0;
            rf_raddr   <= '0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state      <= DUMP_IDLE;
                cpu_stall  <= 1'b0;
                busy       <= 1'b0;
                dump_valid <= 1'b0;
                rf_raddr   <= '0;
            end else begin
                case (state)
                    DUMP_IDLE: begin
                        rf_raddr <= '0;
                        if (start) begin
                            state     <= DUMP_DRAIN;
                            idx       <= FIRST_IDX;
                            cpu_stall <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    DUMP_DRAIN: begin
                        state    <= DUMP_READ;
                        rf_raddr <= idx;
                    end
                    DUMP_READ: begin
                        dump_data  <= rf_rdata;
                        dump_addr  <= idx;
                        dump_valid <= 1'b1;
                        rf_raddr   <= '0;
                        state      <= DUMP_SEND;
                    end
                    DUMP_SEND: begin
                        if (handshake) begin
                            dump_valid <= 1'b0;
                            if (idx == LAST_IDX) begin
                                state <= DUMP_DONE;
                                done  <= 1'b1;
                            end else begin
                                idx      <= idx + 1'b1;
                                rf_raddr <= idx + 1'b1;
                                state    <= DUMP_READ;
                            end
                        end
                    end
                    DUMP_DONE: begin
                        state     <= DUMP_IDLE;
                        cpu_stall <= 1'b0;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state      <= DUMP_IDLE;
                        cpu_stall  <= 1'b0;
                        busy       <= 1'b0;
                        dump_valid <= 1'b0;
                        rf_raddr   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench: a behavioural register file plus an expected-beat queue per instance.
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    localparam int ONE_ADDR = 8;

    typedef struct packed {
        logic [REG_ADDR_LEN-1:0] addr;
        logic [DATA_LEN-1:0]     data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, abort = 1'b0, dump_ready = 1'b0;
    logic start2 = 1'b0, abort2 = 1'b0, dump_ready2 = 1'b1;
    logic cpu_stall, dump_valid, busy, done;
    logic cpu_stall2, dump_valid2, busy2, done2;
    logic [REG_ADDR_LEN-1:0] rf_raddr, dump_addr, rf_raddr2, dump_addr2;
    logic [DATA_LEN-1:0]     rf_rdata, dump_data, rf_rdata2, dump_data2;

    logic                    cpu_we = 1'b0;
    logic [REG_ADDR_LEN-1:0] cpu_waddr = '0;
    logic [DATA_LEN-1:0]     cpu_wdata = '0;

    logic [DATA_LEN-1:0] rf_mem     [REG_NUM];
    logic [DATA_LEN-1:0] model_regs [REG_NUM];

    beat_t sbQ[$];
    beat_t sbQ2[$];
    int testsRun = 0;
    int testsFailed = 0;

    logic                    holdPending = 1'b0;
    logic [REG_ADDR_LEN-1:0] heldAddr;
    logic [DATA_LEN-1:0]     heldData;

    always #5 clk = ~clk;

    regfile_dump_reader #(.FIRST_ADDR(0), .LAST_ADDR(REG_NUM - 1)) u_full (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cpu_stall(cpu_stall), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .busy(busy), .done(done)
    );

    regfile_dump_reader #(.FIRST_ADDR(ONE_ADDR), .LAST_ADDR(ONE_ADDR)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .cpu_stall(cpu_stall2), .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2),
        .dump_valid(dump_valid2), .dump_ready(dump_ready2),
        .dump_addr(dump_addr2), .dump_data(dump_data2), .busy(busy2), .done(done2)
    );

    // Register file: asynchronous read, $0 hardwired to zero, writes frozen while stalled.
    assign rf_rdata  = (rf_raddr == '0)  ? '0 : rf_mem[rf_raddr];
    assign rf_rdata2 = (rf_raddr2 == '0) ? '0 : rf_mem[rf_raddr2];

    always @(posedge clk) begin
        if (cpu_we && !(cpu_stall || cpu_stall2) && cpu_waddr != '0)
            rf_mem[cpu_waddr] <= cpu_wdata;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int expLatency(input int first, input int last);
        return 1 + 2 * (last - first + 1);
    endfunction

    // Inputs change 1 time unit after the rising edge; the monitors sample on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        beat_t exp;
        if (!rst_n) begin
            holdPending = 1'b0;
        end else begin
            if (holdPending) begin
                checkOutput("hold_stable", {dump_valid, dump_addr, dump_data},
                            {1'b1, heldAddr, heldData});
                holdPending = 1'b0;
            end
            if (dump_valid && !abort) begin
                if (dump_ready) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpected_beat", {dump_addr, dump_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        exp = sbQ.pop_front();
                        checkOutput("beat", {dump_addr, dump_data}, exp);
                    end
                end else begin
                    holdPending = 1'b1;
                    heldAddr    = dump_addr;
                    heldData    = dump_data;
                end
            end
        end
    end

    always @(negedge clk) begin
        beat_t exp;
        if (rst_n && dump_valid2 && dump_ready2 && !abort2) begin
            if (sbQ2.size() == 0) begin
                checkOutput("unexpected_beat_one", {dump_addr2, dump_data2}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp = sbQ2.pop_front();
                checkOutput("beat_one", {dump_addr2, dump_data2}, exp);
            end
        end
    end

    task automatic writeReg(input int a, input logic [DATA_LEN-1:0] d);
        cpu_we    = 1'b1;
        cpu_waddr = to_reg_addr(a);
        cpu_wdata = d;
        tick();
        cpu_we = 1'b0;
        if (a != 0) model_regs[a] = d;
    endtask

    // Pulse start (optionally with a same-cycle CPU write to $5) and queue the expected dump.
    task automatic applyStimulus(input bit collide);
        start = 1'b1;
        if (collide) begin
            cpu_we    = 1'b1;
            cpu_waddr = 5'd5;
            cpu_wdata = 32'hDEAD_BEEF;
            model_regs[5] = 32'hDEAD_BEEF;
        end
        for (int a = 0; a < REG_NUM; a++)
            sbQ.push_back({to_reg_addr(a), model_regs[a]});
        tick();
        start  = 1'b0;
        cpu_we = 1'b0;
    endtask

    // policy 0: ready high, 1: random ready, 2: ready held low 5 cycles on beat 3.
    task automatic runDump(input int policy, input int abortAddr, input int resetAddr,
                           output int cycles);
        int holdCnt = 0;
        int gapStep = 0;
        bit finished = 1'b0;
        cycles = 0;
        while (!finished && cycles < 400) begin
            if (abortAddr >= 0 && dump_valid && dump_addr == to_reg_addr(abortAddr)) begin
                abort = 1'b1;
                dump_ready = 1'b1;
                cpu_we = 1'b0;
                tick();
                abort = 1'b0;
                checkOutput("abort_outputs", {dump_valid, busy, cpu_stall, done}, 0);
                sbQ.delete();
                for (int i = 0; i < 4; i++) begin
                    tick();
                    checkOutput("abort_no_done", {done, busy, cpu_stall}, 0);
                end
                finished = 1'b1;
            end else if (resetAddr >= 0 && dump_valid && dump_addr == to_reg_addr(resetAddr)) begin
                cpu_we = 1'b0;
                #2;
                rst_n = 1'b0;
                #1;
                checkOutput("async_reset_outputs",
                            {dump_valid, cpu_stall, busy, done, rf_raddr, dump_addr, dump_data}, 0);
                sbQ.delete();
                tick();
                rst_n = 1'b1;
                tick();
                tick();
                checkOutput("idle_after_reset", {dump_valid, cpu_stall, busy, done}, 0);
                finished = 1'b1;
            end else begin
                case (policy)
                    0: dump_ready = 1'b1;
                    1: dump_ready = 1'($urandom_range(0, 1));
                    default: begin
                        dump_ready = !(dump_valid && dump_addr == 5'd3 && holdCnt < 5);
                        if (!dump_ready) holdCnt++;
                    end
                endcase
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_waddr = 5'($urandom_range(1, REG_NUM - 1));
                cpu_wdata = $urandom;
                if (policy == 2 && gapStep == 0 && dump_valid && dump_ready && dump_addr == 5'd3)
                    gapStep = 1;
                tick();
                cycles++;
                if (gapStep == 1) begin
                    checkOutput("gap_valid_low", dump_valid, 0);
                    gapStep = 2;
                end else if (gapStep == 2) begin
                    checkOutput("gap_next_beat", {dump_valid, dump_addr}, {1'b1, 5'd4});
                    gapStep = 3;
                end
                if (done) begin
                    finished = 1'b1;
                    cpu_we = 1'b0;
                end else begin
                    checkOutput("stall_during_dump", {cpu_stall, busy}, 2'b11);
                end
            end
        end
        cpu_we = 1'b0;
        checkOutput("dump_finished", finished, 1);
    endtask

    task automatic checkIdleAfterDone();
        tick();
        checkOutput("idle_after_done", {cpu_stall, busy, done, dump_valid}, 0);
    endtask

    initial begin
        int lat;
        for (int a = 0; a < REG_NUM; a++) model_regs[a] = '0;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_outputs",
                    {dump_valid, cpu_stall, busy, done, rf_raddr, dump_addr, dump_data}, 0);
        checkOutput("reset_outputs_one",
                    {dump_valid2, cpu_stall2, busy2, done2, rf_raddr2, dump_addr2, dump_data2}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int a = 1; a < REG_NUM; a++) writeReg(a, $urandom);

        // Full dump with ready tied high: latency and continuous stall.
        applyStimulus(1'b0);
        runDump(0, -1, -1, lat);
        checkOutput("full_latency", lat, expLatency(0, REG_NUM - 1));
        checkIdleAfterDone();

        // Backpressure on beat 3.
        applyStimulus(1'b0);
        runDump(2, -1, -1, lat);
        checkIdleAfterDone();

        // CPU write to $5 in the start cycle must be visible in the dump.
        writeReg(5, 32'h0BAD_F00D);
        applyStimulus(1'b1);
        runDump(1, -1, -1, lat);
        checkIdleAfterDone();

        // start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        checkOutput("start_abort_idle", {busy, cpu_stall}, 0);

        // Abort in SEND on beat 10, then a clean restart from addr 0.
        applyStimulus(1'b0);
        runDump(0, 10, -1, lat);
        applyStimulus(1'b0);
        runDump(1, -1, -1, lat);
        checkIdleAfterDone();

        // Asynchronous reset while beat 20 is presented.
        applyStimulus(1'b0);
        runDump(0, -1, 20, lat);

        // Single-register range: one beat, start while busy ignored.
        sbQ2.push_back({to_reg_addr(ONE_ADDR), model_regs[ONE_ADDR]});
        start2 = 1'b1;
        tick();
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            start2 = (i == 0);
            tick();
            lat++;
            if (done2) break;
        end
        start2 = 1'b0;
        checkOutput("one_latency", lat, expLatency(ONE_ADDR, ONE_ADDR));
        for (int i = 0; i < 4; i++) tick();
        checkOutput("one_start_ignored", {busy2, done2, dump_valid2}, 0);

        // Randomised register contents and ready patterns.
        for (int n = 0; n < 3; n++) begin
            for (int w = 0; w < 6; w++) writeReg($urandom_range(0, REG_NUM - 1), $urandom);
            applyStimulus(1'b0);
            runDump(1, -1, -1, lat);
            checkIdleAfterDone();
        end

        tick();
        checkOutput("scoreboard_empty", sbQ.size(), 0);
        checkOutput("scoreboard_one_empty", sbQ2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/trace block. On command, it walks a range of general-purpose registers through one asynchronous read port of the register file.
- Each register value goes out as an {address, data} beat on a valid/ready stream, for the trace UART or the testbench scoreboard.
- It holds the CPU stalled for the whole dump so the register file is not written mid-dump.
- It is the reader/initiator on the register-file read interface.

Parameters:
- FIRST_ADDR, 0: first register index dumped.
- LAST_ADDR, `REG_NUM-1 (31): last register index dumped. Must be >= FIRST_ADDR.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle dump request, sampled only in IDLE
- abort  input  1  cancel an in-progress dump
- cpu_stall  output  1  freezes PC and register-file write enable while high
- rf_raddr  output  `REG_ADDR_LEN (5)  read address to the register-file read port
- rf_rdata  input  `DATA_LEN (32)  asynchronous read data, valid in the same cycle as rf_raddr
- dump_valid  output  1  beat valid
- dump_ready  input  1  sink ready
- dump_addr  output  `REG_ADDR_LEN  register index of the current beat
- dump_data  output  `DATA_LEN  register value of the current beat
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the last beat is accepted

Behaviour:
- Reset (async, rst_n low): state=IDLE, idx=FIRST_ADDR. cpu_stall, dump_valid, busy and done are 0. rf_raddr, dump_addr and dump_data are 0.
- States: IDLE, DRAIN, READ, SEND, DONE.
- IDLE:
  - rf_raddr=0.
  - start=1 -> DRAIN, idx<=FIRST_ADDR.
  - start is ignored in every other state.
- DRAIN:
  - One cycle. cpu_stall=1, so a register write in flight at this edge lands before the first read.
  - -> READ.
- READ:
  - One cycle. rf_raddr=idx.
  - At the edge: dump_data<=rf_rdata, dump_addr<=idx, dump_valid<=1, -> SEND.
- SEND:
  - dump_valid=1. dump_addr and dump_data are held stable until the handshake.
  - Handshake = dump_valid & dump_ready at a rising edge. On handshake:
    - dump_valid<=0.
    - If idx==LAST_ADDR -> DONE.
    - Else idx<=idx+1 -> READ.
  - dump_ready low holds SEND indefinitely.
- DONE:
  - One cycle. done=1, cpu_stall=1.
  - -> IDLE. cpu_stall drops on the IDLE cycle.
- cpu_stall is high in DRAIN, READ, SEND and DONE.
- Throughput with dump_ready tied high: 2 cycles per register.
- Total latency from the start edge to the done pulse: 1 + 2*(LAST_ADDR-FIRST_ADDR+1) cycles, i.e. 65 cycles for the full range. IDLE is re-entered one cycle later.
- Register 0 is dumped as read. The register file returns 0 for it; this block does not special-case it.
- idx never wraps: the increment happens only when idx<LAST_ADDR, so idx=31 never goes to 0.
- abort=1 in any non-IDLE state:
  - Next state is IDLE. dump_valid, cpu_stall and busy go to 0 at that edge. No done pulse.
  - abort takes priority over a simultaneous handshake; that beat counts as not delivered.
  - This is the only case where dump_valid may drop without a handshake.
- start and abort together in IDLE: abort wins; the block stays in IDLE.
- Reset asserted mid-dump: immediate return to the reset values. cpu_stall drops asynchronously.

Decomposition:
- Use `REG_ADDR_LEN, `DATA_LEN and `REG_NUM from defines.v.
- Add the state encodings to defines.v as `define constants: DUMP_IDLE, DUMP_DRAIN, DUMP_READ, DUMP_SEND, DUMP_DONE, 3 bits.
- Single module, no sub-module. The FSM and index counter are small enough to stay inline.

Test Plan:
- Full dump, ready always high. Preload $1=0x11111111 through $31=0x1F1F1F1F; pulse start -> 32 beats, addr 0..31, data 0, 0x11111111, ..., 0x1F1F1F1F. done pulses exactly 65 cycles after the start edge. cpu_stall is high the whole time.
- Backpressure. dump_ready low for 5 cycles on beat 3 -> dump_valid stays high, addr=3 and data stay stable throughout. Beat 4 follows 2 cycles after the handshake. No beat lost or duplicated.
- Write collision. The CPU writes $5=0xDEADBEEF in the same cycle as start -> beat 5 carries 0xDEADBEEF, because DRAIN lets the write land. No register-file writes occur while cpu_stall is high.
- Abort. Assert abort while in SEND on beat 10 -> next cycle dump_valid=0, busy=0, cpu_stall=0, done never pulses. A new start then restarts at addr 0.
- Parameterised range FIRST_ADDR=8, LAST_ADDR=8 -> exactly one beat, addr 8. done arrives 3 cycles after start. start pulsed while busy is ignored.
- Async reset asserted mid-dump (beat 20) -> all outputs go to 0 without a clock edge. After reset is released, the block is in IDLE.
